// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Stall/forward controller for the in-order MIPS pipeline. Every in-flight GPR
// producer is tracked in a STAGES-deep shift register (stage 1 = E, last = W).
// Each decode source operand gets a forward select or raises a stall. HI/LO
// readiness after mult/div is tracked with a saturating down-counter.
module hazard_scoreboard #(
  parameter int STAGES  = 3,
  parameter int NSRC    = 2,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int KEEP    = STAGES
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                hold_i,
  input  logic                flush_i,
  input  logic                d_wr_i,
  input  logic [4:0]          d_dst_i,
  input  logic [2:0]          d_rdy_i,
  input  logic [NSRC*5-1:0]   d_src_i,
  input  logic [NSRC-1:0]     d_use_i,
  input  logic                d_hilo_i,
  input  logic                e_mul_i,
  input  logic                e_div_i,
  output logic                stall_o,
  output logic [NSRC*3-1:0]   fwd_sel_o,
  output logic                busy_o
);

  localparam int CW = $clog2(DIV_LAT + 1);

  logic            stageVld [1:STAGES];
  logic [4:0]      stageDst [1:STAGES];
  logic [2:0]      stageRdy [1:STAGES];
  logic [CW-1:0]   cnt;
  logic [NSRC-1:0] opStall;
  logic [4:0]      srcReg;
  logic            hiloStall;

  // Per-operand match: scan oldest to youngest so the youngest match overrides.
  // An entry whose rdy exceeds its stage index stalls; rdy > STAGES therefore
  // stalls until the entry retires and never forwards.
  always_comb begin
    opStall   = '0;
    fwd_sel_o = '0;
    srcReg    = '0;
    for (int j = 0; j < NSRC; j++) begin
      srcReg = d_src_i[5*j +: 5];
      for (int k = STAGES; k >= 1; k--) begin
        if (stageVld[k] && (stageDst[k] != 5'd0) && (stageDst[k] == srcReg) && d_use_i[j]) begin
          if (k >= int'(stageRdy[k])) begin
            fwd_sel_o[3*j +: 3] = 3'(k);
            opStall[j]          = 1'b0;
          end else begin
            fwd_sel_o[3*j +: 3] = 3'd0;
            opStall[j]          = 1'b1;
          end
        end
      end
    end
  end

  // HI/LO consumers wait for a running count or a mult/div currently in E.
  always_comb begin
    hiloStall = d_hilo_i & ((cnt != '0) | e_mul_i | e_div_i);
    stall_o   = (|opStall) | hiloStall;
    busy_o    = (cnt != '0);
  end

  // Producer shift register: hold freezes, flush drops the young stages.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 1; k <= STAGES; k++) begin
        stageVld[k] <= 1'b0;
        stageDst[k] <= 5'd0;
        stageRdy[k] <= 3'd0;
      end
    end else if (!hold_i) begin
      if (flush_i) begin
        stageVld[1] <= 1'b0;
        for (int k = 2; k <= STAGES; k++) begin
          stageVld[k] <= ((k - 1) >= KEEP) ? stageVld[k-1] : 1'b0;
        end
      end else begin
        stageVld[1] <= d_wr_i & ~stall_o & (d_dst_i != 5'd0);
        for (int k = 2; k <= STAGES; k++) begin
          stageVld[k] <= stageVld[k-1];
        end
      end
      stageDst[1] <= d_dst_i;
      stageRdy[1] <= d_rdy_i;
      for (int k = 2; k <= STAGES; k++) begin
        stageDst[k] <= stageDst[k-1];
        stageRdy[k] <= stageRdy[k-1];
      end
    end
  end

  // HI/LO busy countdown; div wins over mult, a new start overrides a running count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (!hold_i) begin
      if (e_div_i) begin
        cnt <= CW'(DIV_LAT);
      end else if (e_mul_i) begin
        cnt <= CW'(MUL_LAT);
      end else if (cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (default parameters: STAGES=3, KEEP=3,
// MUL_LAT=5, DIV_LAT=10).
module tb_hazard_scoreboard;

  logic       clk;
  logic       reset_n;
  logic       holdI;
  logic       flushI;
  logic       dWr;
  logic [4:0] dDst;
  logic [2:0] dRdy;
  logic [9:0] dSrc;
  logic [1:0] dUse;
  logic       dHilo;
  logic       eMul;
  logic       eDiv;
  logic       stall;
  logic [5:0] fwdSel;
  logic       busy;

  int total = 0;
  int bad   = 0;

  hazard_scoreboard dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .hold_i    (holdI),
    .flush_i   (flushI),
    .d_wr_i    (dWr),
    .d_dst_i   (dDst),
    .d_rdy_i   (dRdy),
    .d_src_i   (dSrc),
    .d_use_i   (dUse),
    .d_hilo_i  (dHilo),
    .e_mul_i   (eMul),
    .e_div_i   (eDiv),
    .stall_o   (stall),
    .fwd_sel_o (fwdSel),
    .busy_o    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearD();
    dWr = 1'b0; dDst = 5'd0; dRdy = 3'd0; dSrc = 10'd0; dUse = 2'b00;
    dHilo = 1'b0; eMul = 1'b0; eDiv = 1'b0; holdI = 1'b0; flushI = 1'b0;
  endtask

  task automatic issue(input logic [4:0] dst, input logic [2:0] rdy);
    clearD();
    dWr = 1'b1; dDst = dst; dRdy = rdy;
  endtask

  task automatic readOps(input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] use_);
    clearD();
    dSrc = {s1, s0}; dUse = use_;
  endtask

  task automatic drain();
    clearD();
    repeat (3) tick();
  endtask

  initial begin
    reset_n = 1'b0;
    clearD();
    #12;
    chk("reset_stall", stall, 0);
    chk("reset_fwd", fwdSel, 0);
    chk("reset_busy", busy, 0);
    reset_n = 1'b1;
    tick();

    // lw $1, nop, addu $2,$1,$1: one stall (lw in M), then both from W
    issue(5'd1, 3'd3); tick();
    clearD(); tick();
    readOps(5'd1, 5'd1, 2'b11); #1;
    chk("lw_stall", stall, 1);
    chk("lw_stall_fwd", fwdSel, 0);
    tick();
    chk("lw_fwd_stall", stall, 0);
    chk("lw_fwd", fwdSel, 6'b011_011);
    drain();

    // ori $3 (rdy=2) then beq $3,$3
    issue(5'd3, 3'd2); tick();
    readOps(5'd3, 5'd3, 2'b11); #1;
    chk("ori_stall", stall, 1);
    chk("ori_stall_fwd", fwdSel, 0);
    tick();
    chk("ori_fwd_stall", stall, 0);
    chk("ori_fwd", fwdSel, 6'b010_010);
    drain();

    // jal in E, jr $31 in D
    issue(5'd31, 3'd1); tick();
    readOps(5'd31, 5'd0, 2'b01); #1;
    chk("jal_stall", stall, 0);
    chk("jal_fwd", fwdSel, 6'b000_001);
    drain();

    // lw $4 in M, addu $4 in E: youngest wins
    issue(5'd4, 3'd3); tick();
    issue(5'd4, 3'd2); tick();
    readOps(5'd4, 5'd0, 2'b01); #1;
    chk("young_stall", stall, 1);
    tick();
    chk("young_fwd_stall", stall, 0);
    chk("young_fwd", fwdSel, 6'b000_010);
    drain();

    // $0 producer never stalls; unused operand never matches
    issue(5'd0, 3'd3); tick();
    readOps(5'd0, 5'd0, 2'b11); #1;
    chk("r0_stall", stall, 0);
    chk("r0_fwd", fwdSel, 0);
    issue(5'd5, 3'd3); tick();
    readOps(5'd5, 5'd5, 2'b00); #1;
    chk("nouse_stall", stall, 0);
    chk("nouse_fwd", fwdSel, 0);
    drain();

    // rdy > STAGES: stalls in every stage, retires, never forwards
    issue(5'd6, 3'd4); tick();
    readOps(5'd6, 5'd0, 2'b01); #1;
    for (int i = 0; i < 3; i++) begin
      chk("badrdy_stall", stall, 1);
      chk("badrdy_fwd", fwdSel, 0);
      tick();
    end
    chk("badrdy_done_stall", stall, 0);
    chk("badrdy_done_fwd", fwdSel, 0);
    drain();

    // div in E with mflo in D: 11 stall cycles, busy for 10
    clearD(); dHilo = 1'b1; eDiv = 1'b1; #1;
    chk("div_e_stall", stall, 1);
    chk("div_e_busy", busy, 0);
    tick();
    eDiv = 1'b0; #1;
    for (int i = 0; i < 10; i++) begin
      chk("div_stall", stall, 1);
      chk("div_busy", busy, 1);
      tick();
    end
    chk("div_end_stall", stall, 0);
    chk("div_end_busy", busy, 0);

    // mult in E stalls an HI/LO reader even with the count at zero
    clearD(); dHilo = 1'b1; eMul = 1'b1; #1;
    chk("mul_e_stall", stall, 1);

    // running div re-armed by mult to MUL_LAT
    clearD(); eDiv = 1'b1; tick();
    clearD(); tick();
    eMul = 1'b1; tick();
    clearD(); #1;
    for (int i = 0; i < 5; i++) begin
      chk("mul_rearm_busy", busy, 1);
      tick();
    end
    chk("mul_rearm_end", busy, 0);

    // both asserted: DIV_LAT wins
    clearD(); eDiv = 1'b1; eMul = 1'b1; tick();
    clearD(); #1;
    for (int i = 0; i < 10; i++) begin
      chk("both_busy", busy, 1);
      tick();
    end
    chk("both_end", busy, 0);

    // hold for 3 cycles: entry and count frozen, new div ignored
    issue(5'd7, 3'd2); eMul = 1'b1; tick();
    readOps(5'd7, 5'd0, 2'b01); holdI = 1'b1; eDiv = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      chk("hold_stall", stall, 1);
      chk("hold_busy", busy, 1);
      tick();
    end
    holdI = 1'b0; eDiv = 1'b0; #1;
    chk("hold_rel_stall", stall, 1);
    tick();
    chk("hold_after_stall", stall, 0);
    chk("hold_after_fwd", fwdSel, 6'b000_010);
    clearD(); #1;
    for (int i = 0; i < 4; i++) begin
      chk("hold_cnt_busy", busy, 1);
      tick();
    end
    chk("hold_cnt_end", busy, 0);
    drain();

    // flush with entries in E, M, W (KEEP=3)
    issue(5'd5, 3'd1); tick();
    issue(5'd6, 3'd1); tick();
    issue(5'd7, 3'd1); tick();
    readOps(5'd5, 5'd6, 2'b11); #1;
    chk("preflush_fwd", fwdSel, 6'b010_011);
    holdI = 1'b1; flushI = 1'b1; tick();
    holdI = 1'b0; flushI = 1'b0; #1;
    chk("holdflush_fwd", fwdSel, 6'b010_011);
    flushI = 1'b1; dWr = 1'b1; dDst = 5'd8; dRdy = 3'd1; tick();
    readOps(5'd6, 5'd7, 2'b11); #1;
    chk("flush_fwd_a", fwdSel, 0);
    readOps(5'd8, 5'd5, 2'b11); #1;
    chk("flush_fwd_b", fwdSel, 0);
    chk("flush_stall", stall, 0);
    drain();

    // async reset mid-div
    issue(5'd9, 3'd3); eDiv = 1'b1; tick();
    readOps(5'd9, 5'd0, 2'b01); dHilo = 1'b1; #1;
    chk("prerst_stall", stall, 1);
    chk("prerst_busy", busy, 1);
    tick();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall, 0);
    chk("rst_fwd", fwdSel, 0);
    reset_n = 1'b1;
    tick();
    chk("postrst_stall", stall, 0);
    chk("postrst_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
